// File: rtl/passthrough_arbiter.sv
// passthrough_arbiter: two-requester round-robin arbiter feeding one
// registered 16-bit passThrough output stage. A grant is held for a whole
// packet (until a last=1 beat is accepted), then priority moves to the other
// requester. Optional macro PT_ARB_STATS_EN adds saturating per-requester
// completed-packet counters (pkt_cnt0/pkt_cnt1, CNT_W bits wide).
module passthrough_arbiter #(
   parameter int DATA_W = 16,
   parameter int SIG_W  = 2
`ifdef PT_ARB_STATS_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [SIG_W-1:0]  req0_sig,
   input  logic              req0_last,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_data,
   input  logic [SIG_W-1:0]  req1_sig,
   input  logic              req1_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SIG_W-1:0]  out_sig,
   output logic              out_src,
   output logic              out_last,
   output logic              busy
`ifdef PT_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                prio_q, prio_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [SIG_W-1:0]    out_sig_q, out_sig_d;
   logic                out_src_q, out_src_d;
   logic                out_last_q, out_last_d;

   logic                slot_free;
   logic                grant_vld;
   logic                grant_idx;
   logic                sel_valid;
   logic                sel_last;
   logic [DATA_W-1:0]   sel_data;
   logic [SIG_W-1:0]    sel_sig;
   logic                accept;

   // The output register can take a new beat when empty or being drained.
   assign slot_free = !out_valid_q || out_ready;

   // Choose the granted requester: favoured one first in IDLE, else the locked owner.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 1'b0;
      case (state_q)
         IDLE: begin
            if (prio_q ? req1_valid : req0_valid) begin
               grant_vld = 1'b1;
               grant_idx = prio_q;
            end else if (prio_q ? req0_valid : req1_valid) begin
               grant_vld = 1'b1;
               grant_idx = ~prio_q;
            end
         end
         LOCK0: begin
            grant_vld = 1'b1;
            grant_idx = 1'b0;
         end
         LOCK1: begin
            grant_vld = 1'b1;
            grant_idx = 1'b1;
         end
         default: begin
            grant_vld = 1'b0;
            grant_idx = 1'b0;
         end
      endcase
   end

   // Route the granted requester's beat toward the output register.
   always_comb begin
      sel_valid = req0_valid;
      sel_last  = req0_last;
      sel_data  = req0_data;
      sel_sig   = req0_sig;
      if (grant_idx) begin
         sel_valid = req1_valid;
         sel_last  = req1_last;
         sel_data  = req1_data;
         sel_sig   = req1_sig;
      end
   end

   // Ready is held low while reset is asserted so nothing looks accepted then.
   assign req0_ready = !rst && grant_vld && !grant_idx && slot_free;
   assign req1_ready = !rst && grant_vld &&  grant_idx && slot_free;
   assign accept     = grant_vld && sel_valid && slot_free;

   // Packet locking and round-robin pointer update on accepted beats.
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      if (accept) begin
         if (sel_last) begin
            state_d = IDLE;
            prio_d  = ~grant_idx;
         end else begin
            state_d = grant_idx ? LOCK1 : LOCK0;
         end
      end
   end

   // Output stage: load on acceptance, drop valid when drained with nothing new.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sig_d   = out_sig_q;
      out_src_d   = out_src_q;
      out_last_d  = out_last_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_sig_d   = sel_sig;
         out_src_d   = grant_idx;
         out_last_d  = sel_last;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State, priority and output registers; reset discards any partial packet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sig_q   <= '0;
         out_src_q   <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sig_q   <= out_sig_d;
         out_src_q   <= out_src_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sig   = out_sig_q;
   assign out_src   = out_src_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != IDLE);

`ifdef PT_ARB_STATS_EN
   logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
   logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Count completed packets per requester, sticking at all-ones.
   always_comb begin
      pkt_cnt0_d = pkt_cnt0_q;
      pkt_cnt1_d = pkt_cnt1_q;
      if (accept && sel_last) begin
         if (!grant_idx && (pkt_cnt0_q != '1)) begin
            pkt_cnt0_d = pkt_cnt0_q + CNT_ONE;
         end
         if (grant_idx && (pkt_cnt1_q != '1)) begin
            pkt_cnt1_d = pkt_cnt1_q + CNT_ONE;
         end
      end
   end

   // Packet counter registers, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt0_q <= '0;
         pkt_cnt1_q <= '0;
      end else begin
         pkt_cnt0_q <= pkt_cnt0_d;
         pkt_cnt1_q <= pkt_cnt1_d;
      end
   end

   assign pkt_cnt0 = pkt_cnt0_q;
   assign pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule

// File: tb/tb_passthrough_arbiter.sv
// Testbench for passthrough_arbiter. Requesters are fed from per-requester
// beat queues; output handshakes are logged and compared against sequences
// the bench derives from the round-robin, packet-locking rules.
module tb_passthrough_arbiter;

   localparam int DATA_W = 16;
   localparam int SIG_W  = 2;
`ifdef PT_ARB_STATS_EN
   localparam int CNT_W  = 2;
`endif

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  sig;
      logic        last;
   } beat_t;

   typedef struct {
      logic        src;
      logic [15:0] data;
      logic [1:0]  sig;
      logic        last;
      int          cyc;
   } obs_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req0_valid = 1'b0;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_data = '0;
   logic [SIG_W-1:0]  req0_sig = '0;
   logic              req0_last = 1'b0;
   logic              req1_valid = 1'b0;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_data = '0;
   logic [SIG_W-1:0]  req1_sig = '0;
   logic              req1_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [SIG_W-1:0]  out_sig;
   logic              out_src;
   logic              out_last;
   logic              busy;
`ifdef PT_ARB_STATS_EN
   logic [CNT_W-1:0]  pkt_cnt0;
   logic [CNT_W-1:0]  pkt_cnt1;
`endif

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   bit    gate0 = 1'b1;
   bit    gate1 = 1'b1;
   bit    hs0, hs1;
   beat_t q0[$];
   beat_t q1[$];
   obs_t  obs_q[$];

   passthrough_arbiter #(
      .DATA_W(DATA_W),
      .SIG_W (SIG_W)
`ifdef PT_ARB_STATS_EN
      ,
      .CNT_W (CNT_W)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req0_valid(req0_valid),
      .req0_ready(req0_ready),
      .req0_data (req0_data),
      .req0_sig  (req0_sig),
      .req0_last (req0_last),
      .req1_valid(req1_valid),
      .req1_ready(req1_ready),
      .req1_data (req1_data),
      .req1_sig  (req1_sig),
      .req1_last (req1_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sig   (out_sig),
      .out_src   (out_src),
      .out_last  (out_last),
      .busy      (busy)
`ifdef PT_ARB_STATS_EN
      ,
      .pkt_cnt0  (pkt_cnt0),
      .pkt_cnt1  (pkt_cnt1)
`endif
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Requester driver and output logger: sample handshakes mid-cycle, advance after the edge.
   always begin
      obs_t o;
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (out_valid && out_ready) begin
         o.src  = out_src;
         o.data = out_data;
         o.sig  = out_sig;
         o.last = out_last;
         o.cyc  = cyc;
         obs_q.push_back(o);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      if (gate0 && q0.size() > 0) begin
         req0_valid = 1'b1;
         req0_data  = q0[0].data;
         req0_sig   = q0[0].sig;
         req0_last  = q0[0].last;
      end else begin
         req0_valid = 1'b0;
      end
      if (gate1 && q1.size() > 0) begin
         req1_valid = 1'b1;
         req1_data  = q1[0].data;
         req1_sig   = q1[0].sig;
         req1_last  = q1[0].last;
      end else begin
         req1_valid = 1'b0;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      gate0 = 1'b1;
      gate1 = 1'b1;
      @(posedge clk);
      #2;
      q0.delete();
      q1.delete();
      @(posedge clk);
      #2;
      obs_q.delete();
      rst = 1'b0;
   endtask

   task automatic wait_obs(input int n, input int budget, output bit ok);
      int cnt = 0;
      while (obs_q.size() < n && cnt < budget) begin
         @(posedge clk);
         cnt++;
      end
      ok = (obs_q.size() >= n);
   endtask

   task automatic push_beat(input bit r, input logic [15:0] d, input logic [1:0] s, input logic l);
      beat_t b;
      b.data = d;
      b.sig  = s;
      b.last = l;
      if (r) q1.push_back(b);
      else   q0.push_back(b);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      gate0 = 1'b1;
      gate1 = 1'b1;
      q0.delete();
      q1.delete();
      push_beat(1'b0, 16'h1234, 2'b01, 1'b1);
      repeat (2) @(posedge clk);
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0000", out_data); end
      checks++; if (out_sig !== 2'b00) begin errors++; $display("[TB] FAIL reset_out_sig: got %b expected 00", out_sig); end
      checks++; if (out_src !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_src: got %b expected 0", out_src); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req0_ready: got %b expected 0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req1_ready: got %b expected 0", req1_ready); end
      obs_q.delete();
      rst = 1'b0;
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_req0_ready: got %b expected 1", req0_ready); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_beat_valid: got %b expected 1", out_valid); end
      checks++; if (out_src !== 1'b0) begin errors++; $display("[TB] FAIL first_beat_src: got %b expected 0", out_src); end
      checks++; if (out_data !== 16'h1234 || out_sig !== 2'b01 || out_last !== 1'b1) begin
         errors++; $display("[TB] FAIL first_beat_payload: got %h/%b/%b expected 1234/01/1", out_data, out_sig, out_last);
      end
   endtask

   task automatic test_alternate();
      bit ok;
      logic [15:0] exp_data;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         push_beat(1'b0, 16'(16'h1000 + i), 2'(i), 1'b1);
         push_beat(1'b1, 16'(16'h2000 + i), 2'(~i), 1'b1);
      end
      wait_obs(16, 100, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL alt_count: got %0d beats expected 16", obs_q.size()); end
      for (int j = 0; j < 16 && j < obs_q.size(); j++) begin
         exp_data = ((j % 2) == 1) ? 16'(16'h2000 + j / 2) : 16'(16'h1000 + j / 2);
         checks++;
         if (obs_q[j].src !== 1'(j % 2) || obs_q[j].data !== exp_data || obs_q[j].last !== 1'b1) begin
            errors++; $display("[TB] FAIL alt_beat%0d: got src %b data %h expected src %0d data %h", j, obs_q[j].src, obs_q[j].data, j % 2, exp_data);
         end
         if (j > 0) begin
            checks++;
            if (obs_q[j].cyc != obs_q[0].cyc + j) begin
               errors++; $display("[TB] FAIL alt_rate%0d: got cycle %0d expected %0d", j, obs_q[j].cyc, obs_q[0].cyc + j);
            end
         end
      end
   endtask

   task automatic test_lock();
      bit ok;
      bit exp_busy;
      logic [15:0] exp_d [6];
      logic        exp_s [6];
      exp_d = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00B0, 16'h00B1};
      exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      for (int i = 0; i < 4; i++) push_beat(1'b0, 16'(16'h00A0 + i), 2'b10, (i == 3));
      push_beat(1'b1, 16'h00B0, 2'b11, 1'b1);
      push_beat(1'b1, 16'h00B1, 2'b11, 1'b1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid) begin
            exp_busy = (out_data == 16'h00A0 || out_data == 16'h00A1 || out_data == 16'h00A2);
            checks++;
            if (busy !== exp_busy) begin errors++; $display("[TB] FAIL lock_busy: got %b expected %b at data %h", busy, exp_busy, out_data); end
            if (exp_busy) begin
               checks++;
               if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL lock_req1_ready: got %b expected 0", req1_ready); end
            end
         end
      end
      wait_obs(6, 40, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL lock_count: got %0d beats expected 6", obs_q.size()); end
      for (int j = 0; j < 6 && j < obs_q.size(); j++) begin
         checks++;
         if (obs_q[j].src !== exp_s[j] || obs_q[j].data !== exp_d[j] || obs_q[j].cyc != obs_q[0].cyc + j) begin
            errors++; $display("[TB] FAIL lock_beat%0d: got src %b data %h cyc %0d expected src %b data %h cyc %0d",
                               j, obs_q[j].src, obs_q[j].data, obs_q[j].cyc, exp_s[j], exp_d[j], obs_q[0].cyc + j);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      bit seen = 1'b0;
      logic [15:0] held_d;
      logic [1:0]  held_s;
      logic        held_src;
      logic [15:0] exp_data;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         push_beat(1'b0, 16'(16'h1100 + i), 2'b01, 1'b1);
         push_beat(1'b1, 16'(16'h2200 + i), 2'b10, 1'b1);
      end
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk);
         #2;
         if (out_valid) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("[TB] FAIL bp_start: got no output beat expected one"); end
      out_ready = 1'b0;
      held_d = out_data;
      held_s = out_sig;
      held_src = out_src;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== held_d || out_sig !== held_s || out_src !== held_src) begin
            errors++; $display("[TB] FAIL bp_hold%0d: got %b/%h/%b expected 1/%h/%b", c, out_valid, out_data, out_sig, held_d, held_s);
         end
         checks++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_ready%0d: got %b%b expected 00", c, req0_ready, req1_ready);
         end
      end
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      wait_obs(6, 40, ok);
      repeat (5) @(posedge clk);
      checks++; if (obs_q.size() != 6) begin errors++; $display("[TB] FAIL bp_count: got %0d beats expected 6", obs_q.size()); end
      for (int j = 0; j < 6 && j < obs_q.size(); j++) begin
         exp_data = ((j % 2) == 1) ? 16'(16'h2200 + j / 2) : 16'(16'h1100 + j / 2);
         checks++;
         if (obs_q[j].data !== exp_data || obs_q[j].src !== 1'(j % 2)) begin
            errors++; $display("[TB] FAIL bp_beat%0d: got %h expected %h", j, obs_q[j].data, exp_data);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      gate0 = 1'b0;
      for (int i = 0; i < 4; i++) push_beat(1'b1, 16'(16'h00C0 + i), 2'b11, (i == 3));
      push_beat(1'b0, 16'h00D0, 2'b01, 1'b1);
      wait_obs(2, 40, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_start: got %0d beats expected 2", obs_q.size()); end
      #2;
      checks++; if (busy !== 1'b1 || out_data !== 16'h00C2) begin
         errors++; $display("[TB] FAIL mid_locked: got busy %b data %h expected 1 00c2", busy, out_data);
      end
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0 || req1_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_async_reset: got valid %b busy %b data %h ready %b expected 0 0 0000 0", out_valid, busy, out_data, req1_ready);
      end
      q1.delete();
      push_beat(1'b1, 16'h00E0, 2'b10, 1'b1);
      gate0 = 1'b1;
      obs_q.delete();
      @(posedge clk);
      #2;
      rst = 1'b0;
      wait_obs(2, 40, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_resume: got %0d beats expected 2", obs_q.size()); end
      if (obs_q.size() >= 2) begin
         checks++;
         if (obs_q[0].src !== 1'b0 || obs_q[0].data !== 16'h00D0 || obs_q[1].src !== 1'b1 || obs_q[1].data !== 16'h00E0) begin
            errors++; $display("[TB] FAIL mid_order: got %b:%h %b:%h expected 0:00d0 1:00e0", obs_q[0].src, obs_q[0].data, obs_q[1].src, obs_q[1].data);
         end
      end
   endtask

   task automatic test_random();
      obs_t exp_q[$];
      obs_t e;
      int len;
      int cnt = 0;
      bit prev_stall = 1'b0;
      logic [20:0] held;
      do_reset();
      for (int p = 0; p < 20; p++) begin
         for (int r = 0; r < 2; r++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
               e.src  = 1'(r);
               e.data = 16'($urandom);
               e.sig  = 2'($urandom);
               e.last = (b == len - 1);
               e.cyc  = 0;
               exp_q.push_back(e);
               push_beat(e.src, e.data, e.sig, e.last);
            end
         end
      end
      while (obs_q.size() < exp_q.size() && cnt < 3000) begin
         @(posedge clk);
         #2;
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (prev_stall) begin
            checks++;
            if ({out_valid, out_data, out_sig, out_src, out_last} !== held) begin
               errors++; $display("[TB] FAIL rand_hold: got %h expected %h", {out_valid, out_data, out_sig, out_src, out_last}, held);
            end
         end
         if (out_valid && !out_ready) begin
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
               errors++; $display("[TB] FAIL rand_stall_ready: got %b%b expected 00", req0_ready, req1_ready);
            end
         end
         prev_stall = out_valid && !out_ready;
         held = {out_valid, out_data, out_sig, out_src, out_last};
         cnt++;
      end
      out_ready = 1'b1;
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
      for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
         checks++;
         if (obs_q[j].src !== exp_q[j].src || obs_q[j].data !== exp_q[j].data ||
             obs_q[j].sig !== exp_q[j].sig || obs_q[j].last !== exp_q[j].last) begin
            errors++; $display("[TB] FAIL rand_beat%0d: got %b:%h:%b:%b expected %b:%h:%b:%b", j,
                               obs_q[j].src, obs_q[j].data, obs_q[j].sig, obs_q[j].last,
                               exp_q[j].src, exp_q[j].data, exp_q[j].sig, exp_q[j].last);
         end
      end
   endtask

`ifdef PT_ARB_STATS_EN
   task automatic test_stats();
      bit ok;
      do_reset();
      for (int i = 0; i < 5; i++) push_beat(1'b0, 16'(16'h3000 + i), 2'b00, 1'b1);
      for (int i = 0; i < 2; i++) push_beat(1'b1, 16'(16'h4000 + i), 2'b00, 1'b1);
      wait_obs(7, 60, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL stats_count: got %0d beats expected 7", obs_q.size()); end
      checks++; if (pkt_cnt0 !== 2'd3) begin errors++; $display("[TB] FAIL stats_cnt0: got %0d expected 3", pkt_cnt0); end
      checks++; if (pkt_cnt1 !== 2'd2) begin errors++; $display("[TB] FAIL stats_cnt1: got %0d expected 2", pkt_cnt1); end
   endtask
`endif

   initial begin
      $display("[TB] starting passthrough_arbiter bench");
      test_reset();
      test_alternate();
      test_lock();
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef PT_ARB_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/passthrough_arbiter.md
# passthrough_arbiter

Two-requester round-robin arbiter that shares the 16-bit passThrough channel of the top-level interface between two independent producers. Each requester presents packet beats (data, 2-bit sig tag, last flag) over valid/ready. The arbiter locks the grant for a whole packet, then alternates priority. It drives a single registered output stage toward the interface's passThrough consumer.

## Interface
- DATA_W, 16, payload width of each beat
- SIG_W, 2, sideband tag width carried with each beat
- CNT_W, 16, width of packet counters (only with PT_ARB_STATS_EN)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester beat valid
- req0_ready / req1_ready  out  1  beat accepted when valid&&ready
- req0_data / req1_data  in  DATA_W  beat payload
- req0_sig / req1_sig  in  SIG_W  beat tag
- req0_last / req1_last  in  1  final beat of packet
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- out_data  out  DATA_W  registered payload
- out_sig  out  SIG_W  registered tag
- out_src  out  1  requester index of current output beat
- out_last  out  1  registered last flag
- busy  out  1  high while a packet grant is locked (state != IDLE)
- pkt_cnt0 / pkt_cnt1  out  CNT_W  completed packets per requester (only with PT_ARB_STATS_EN)

## Operation
- State machine: IDLE, LOCK0, LOCK1. Priority pointer `prio` (1 bit) names the favoured requester.
- slot_free = !out_valid || out_ready.
- IDLE arbitration is combinational:
  - grant = prio if req[prio]_valid;
  - else the other requester if it is valid;
  - else none.
- Granted requester's ready = slot_free. Non-granted ready = 0 in every state.
- IDLE, accepted beat with last=0 -> LOCK<grant>. Accepted beat with last=1 -> stay IDLE, prio <= ~grant.
- LOCKn: only requester n may transfer. Its ready = slot_free. The other requester's valid is ignored. Accepted beat with last=1 -> IDLE, prio <= ~n.
- Accepted beat loads out_data/out_sig/out_last/out_src and sets out_valid.
- out_valid clears when out_ready is high and no beat is accepted that cycle.
- Single-beat packets from both requesters alternate every cycle: 0,1,0,1...
- A requester that is idle when its turn comes does not block the other. prio only flips on a completed packet.
- Requester valid dropping mid-packet in LOCKn: grant stays locked, output idles. There is no timeout.

## Timing
- Reset values: out_valid=0, out_data=0, out_sig=0, out_src=0, out_last=0, busy=0, req*_ready=0. State is IDLE, prio=0, pkt_cnt*=0.
- Latency: beat accepted at edge k appears on out_* after edge k (one cycle). Throughput is one beat per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, all out_* hold and both req*_ready=0.
- The out_ready to req_ready path is combinational. out_valid/data are registered. There is no combinational path from req data to out_data.
- Simultaneous out handshake and new acceptance: out_* replaced in the same edge, out_valid stays 1.
- Reset asserted mid-packet: partial packet discarded, everything returns to reset values asynchronously. The first post-reset grant favours req0.

## Configuration
- PT_ARB_STATS_EN defined:
  - pkt_cnt0/pkt_cnt1 exist.
  - Each increments on acceptance of a last=1 beat from its requester.
  - Counters saturate at all-ones and clear only on rst.
- Undefined: counter ports and logic absent; all other behaviour identical.

## Test plan
- Reset: rst=1 with req0_valid=1 -> all outputs 0, req0_ready=0. Release rst, out_ready=1 -> first beat accepted on next edge, out_src=0 one cycle later.
- Both requesters stream single-beat packets (last=1), data 0x1000+i / 0x2000+i, out_ready=1 -> out_src alternates 0,1,0,1; out_data sequence 0x1000,0x2000,0x1001,0x2001; one beat per cycle.
- req0 sends a 4-beat packet (0xA0..0xA3, last on 0xA3) while req1_valid=1 throughout -> four req0 beats contiguous, busy=1 for beats 1-3, then req1 granted next.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_sig stable, req*_ready=0; on release, transfers resume with no loss or duplication.
- rst pulse after beat 2 of a 4-beat req1 packet -> out_valid=0 immediately, busy=0, next grant is req0 when both are valid.
- With PT_ARB_STATS_EN, CNT_W=2: req0 completes 5 packets, req1 completes 2 -> pkt_cnt0=3 (saturated), pkt_cnt1=2.
